// File: rtl/ddsm_pkg.sv
// Shared constants and types for the segmented EFM1 accumulator.
package ddsm_pkg;

   localparam int unsigned P_INPUT_WIDTH = 6;
   localparam int unsigned SEG_NUM       = 4;
   localparam int unsigned SEG_W         = P_INPUT_WIDTH;
   localparam int unsigned WORD_W        = SEG_NUM * SEG_W;

   // Arrival skew of each segment relative to the LSB segment, in cycles
   localparam int unsigned SKEW_LSB  = 0;
   localparam int unsigned SKEW_ISB2 = 1;
   localparam int unsigned SKEW_ISB1 = 2;
   localparam int unsigned SKEW_MSB  = 3;

   typedef logic [SEG_W-1:0] seg_t;

endpackage : ddsm_pkg

// File: rtl/seg_pipe_accum_if.sv
// Skewed segment input bus and residue/carry output bus of the accumulator.
interface seg_pipe_accum_if;
   import ddsm_pkg::*;

   logic i_valid;
   logic i_dither;
   seg_t i_lsb;
   seg_t i_isb2;
   seg_t i_isb1;
   seg_t i_msb;
   logic o_carry;
   logic o_valid;
   seg_t o_res_lsb;
   seg_t o_res_isb2;
   seg_t o_res_isb1;
   seg_t o_res_msb;

   modport master (
      output i_valid, i_dither, i_lsb, i_isb2, i_isb1, i_msb,
      input  o_carry, o_valid, o_res_lsb, o_res_isb2, o_res_isb1, o_res_msb
   );

   modport slave (
      input  i_valid, i_dither, i_lsb, i_isb2, i_isb1, i_msb,
      output o_carry, o_valid, o_res_lsb, o_res_isb2, o_res_isb1, o_res_msb
   );

endinterface : seg_pipe_accum_if

// File: rtl/seg_add_stage.sv
// One segment of the accumulator: registered P-bit residue plus registered carry-out.
module seg_add_stage #(
   parameter int unsigned P_W = 6
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_valid,
   input  logic           i_cin,
   input  logic [P_W-1:0] i_seg,
   output logic [P_W-1:0] o_acc,
   output logic           o_carry
);

   localparam int unsigned SUM_W = P_W + 1;

   logic [P_W-1:0] r_acc;
   logic           r_carry;
   logic [P_W:0]   w_sum;

   // Residue + segment + carry-in, widened by one bit to expose the carry
   assign w_sum = SUM_W'(r_acc) + SUM_W'(i_seg) + SUM_W'(i_cin);

   // Accumulate on valid; a bubble holds the residue and emits no carry
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
      end else if (i_valid) begin
         r_acc   <= w_sum[P_W-1:0];
         r_carry <= w_sum[P_W];
      end else begin
         r_carry <= 1'b0;
      end
   end

   assign o_acc   = r_acc;
   assign o_carry = r_carry;

endmodule : seg_add_stage

// File: rtl/seg_pipe_accum.sv
// Pipelined segmented first-order error-feedback accumulator; one segment per cycle.
module seg_pipe_accum
   import ddsm_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   seg_pipe_accum_if.slave   bus
);

   logic [SEG_NUM-1:0] w_vld;
   logic [SEG_NUM-1:0] w_cin;
   logic [SEG_NUM-1:0] w_cout;
   seg_t               w_seg [SEG_NUM];
   seg_t               w_acc [SEG_NUM];
   logic [SEG_NUM-1:1] r_vpipe;
   logic               r_vout;

   // Valid follows the sample down the skew so every segment sees the same gating
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vpipe <= '0;
         r_vout  <= 1'b0;
      end else begin
         r_vpipe <= {r_vpipe[SEG_NUM-2:1], bus.i_valid};
         r_vout  <= r_vpipe[SEG_NUM-1];
      end
   end

   assign w_vld[0]           = bus.i_valid;
   assign w_vld[SEG_NUM-1:1] = r_vpipe;

   assign w_seg[SKEW_LSB]  = bus.i_lsb;
   assign w_seg[SKEW_ISB2] = bus.i_isb2;
   assign w_seg[SKEW_ISB1] = bus.i_isb1;
   assign w_seg[SKEW_MSB]  = bus.i_msb;

   // LSB carry-in is the external dither; higher segments take the previous stage's carry
   assign w_cin[0] = bus.i_dither;

   // One registered adder per segment, chained through the carry registers
   for (genvar k = 0; k < int'(SEG_NUM); k++) begin : g_stage
      if (k > 0) begin : g_chain
         assign w_cin[k] = w_cout[k-1];
      end
      seg_add_stage #(.P_W(SEG_W)) u_stage (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_valid (w_vld[k]),
         .i_cin   (w_cin[k]),
         .i_seg   (w_seg[k]),
         .o_acc   (w_acc[k]),
         .o_carry (w_cout[k])
      );
   end

   assign bus.o_res_lsb  = w_acc[SKEW_LSB];
   assign bus.o_res_isb2 = w_acc[SKEW_ISB2];
   assign bus.o_res_isb1 = w_acc[SKEW_ISB1];
   assign bus.o_res_msb  = w_acc[SKEW_MSB];
   assign bus.o_carry    = w_cout[SEG_NUM-1];
   assign bus.o_valid    = r_vout;

endmodule : seg_pipe_accum

// File: tb/tb_seg_pipe_accum.sv
// Bench for seg_pipe_accum: directed and random phases against a whole-word accumulator model.
module tb_seg_pipe_accum;

   localparam int unsigned MAXN = 300;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic [23:0] ph_x [MAXN];
   logic        ph_v [MAXN];
   logic        ph_d [MAXN];
   logic [23:0] wa   [MAXN];
   logic        cy   [MAXN];

   seg_pipe_accum_if bus ();

   seg_pipe_accum dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] xat(input int t);
      return (t < 0) ? 24'd0 : ph_x[t];
   endfunction

   function automatic logic [23:0] wa_at(input int t);
      return (t < 0) ? 24'd0 : wa[t];
   endfunction

   // Idle tail after a phase so the skewed segments of the last samples drain
   task automatic pad(input int n);
      for (int t = n; t < n + 4; t++) begin
         ph_x[t] = 24'($urandom);
         ph_v[t] = 1'b0;
         ph_d[t] = 1'($urandom);
      end
   endtask

   task automatic fill_const(input int n, input logic [23:0] x, input logic d);
      for (int t = 0; t < n; t++) begin
         ph_x[t] = x;
         ph_v[t] = 1'b1;
         ph_d[t] = d;
      end
      pad(n);
   endtask

   // Reference: the whole 24-bit word accumulates per valid sample, carry = bit 24
   task automatic compute(input int n);
      logic [23:0] w;
      logic [24:0] s;
      w = 24'd0;
      for (int t = 0; t < n + 4; t++) begin
         if (ph_v[t]) begin
            s = 25'(w) + 25'(ph_x[t]) + 25'(ph_d[t]);
            w = s[23:0];
            cy[t] = s[24];
         end else begin
            cy[t] = 1'b0;
         end
         wa[t] = w;
      end
   endtask

   task automatic drive(input int t);
      logic [23:0] xa, xb, xc, xd;
      xa = xat(t);
      xb = xat(t - 1);
      xc = xat(t - 2);
      xd = xat(t - 3);
      bus.i_lsb    = xa[5:0];
      bus.i_isb2   = xb[11:6];
      bus.i_isb1   = xc[17:12];
      bus.i_msb    = xd[23:18];
      bus.i_valid  = ph_v[t];
      bus.i_dither = ph_d[t];
   endtask

   task automatic check_cycle(input string name, input int t);
      logic [23:0] w0, w1, w2, w3;
      logic        ec, ev;
      w0 = wa_at(t);
      w1 = wa_at(t - 1);
      w2 = wa_at(t - 2);
      w3 = wa_at(t - 3);
      ec = (t >= 3) ? cy[t-3]   : 1'b0;
      ev = (t >= 3) ? ph_v[t-3] : 1'b0;
      chk({name, ".res_lsb"},  24'(bus.o_res_lsb),  24'(w0[5:0]));
      chk({name, ".res_isb2"}, 24'(bus.o_res_isb2), 24'(w1[11:6]));
      chk({name, ".res_isb1"}, 24'(bus.o_res_isb1), 24'(w2[17:12]));
      chk({name, ".res_msb"},  24'(bus.o_res_msb),  24'(w3[23:18]));
      chk({name, ".carry"},    24'(bus.o_carry),    24'(ec));
      chk({name, ".valid"},    24'(bus.o_valid),    24'(ev));
   endtask

   task automatic run_phase(input string name, input int n, input bit flush);
      int last;
      compute(n);
      last = flush ? n + 3 : n - 1;
      for (int t = 0; t <= last; t++) begin
         @(negedge clk);
         drive(t);
         @(posedge clk);
         #1;
         check_cycle(name, t);
      end
   endtask

   // Reset is asynchronous: outputs must clear before the next clock edge
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_valid = 1'b0;
      #1;
      chk("rst.res_lsb",  24'(bus.o_res_lsb),  24'd0);
      chk("rst.res_isb2", 24'(bus.o_res_isb2), 24'd0);
      chk("rst.res_isb1", 24'(bus.o_res_isb1), 24'd0);
      chk("rst.res_msb",  24'(bus.o_res_msb),  24'd0);
      chk("rst.carry",    24'(bus.o_carry),    24'd0);
      chk("rst.valid",    24'(bus.o_valid),    24'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.i_valid  = 1'b0;
      bus.i_dither = 1'b0;
      bus.i_lsb    = '0;
      bus.i_isb2   = '0;
      bus.i_isb1   = '0;
      bus.i_msb    = '0;
      repeat (2) @(negedge clk);

      // Half-scale input: carry alternates, MSB residue alternates 32/0
      do_reset();
      fill_const(8, 24'h800000, 1'b0);
      run_phase("half", 8, 1'b1);

      // 2^20 input: one carry every 16th sample
      do_reset();
      fill_const(40, 24'h100000, 1'b0);
      run_phase("sixteenth", 40, 1'b1);

      // Full ripple: 1 then 2^24-1 wraps to exactly zero with a carry
      do_reset();
      fill_const(2, 24'hFFFFFF, 1'b0);
      ph_x[0] = 24'd1;
      run_phase("ripple", 2, 1'b1);

      // Valid gaps: bubbles carry nothing, second valid sample carries
      do_reset();
      fill_const(4, 24'h800000, 1'b0);
      ph_v[1] = 1'b0;
      ph_v[3] = 1'b0;
      ph_x[1] = 24'($urandom);
      ph_x[3] = 24'($urandom);
      run_phase("gaps", 4, 1'b1);

      // Dither on all-ones input: carry every sample, residue stays zero
      do_reset();
      fill_const(10, 24'hFFFFFF, 1'b1);
      run_phase("dither", 10, 1'b1);

      // Random traffic interrupted by reset mid-stream
      do_reset();
      for (int t = 0; t < 20; t++) begin
         ph_x[t] = 24'($urandom);
         ph_v[t] = ($urandom_range(0, 3) != 0);
         ph_d[t] = 1'($urandom);
      end
      pad(20);
      run_phase("midstream", 20, 1'b0);

      // Long random run after the mid-stream reset
      do_reset();
      for (int t = 0; t < 200; t++) begin
         ph_x[t] = 24'($urandom);
         ph_v[t] = ($urandom_range(0, 3) != 0);
         ph_d[t] = 1'($urandom);
      end
      pad(200);
      run_phase("random", 200, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seg_pipe_accum
